// File: rtl/multicycle_core_ctrl_if.sv
// Memory-side handshake bundle for multicycle_core_ctrl.
// Ports: ifu_req/ifu_resp (fetch), lsu_req/lsu_resp (data); master = core.
interface multicycle_core_ctrl_if #(
    parameter int XLEN   = 32,
    parameter int INST_W = 32
);
    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [XLEN-1:0]   ifu_req_addr;
    logic              ifu_resp_valid;
    logic [INST_W-1:0] ifu_resp_inst;
    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic              lsu_req_we;
    logic [XLEN-1:0]   lsu_req_addr;
    logic              lsu_resp_valid;
    logic [XLEN-1:0]   lsu_resp_rdata;

    modport master (
        output ifu_req_valid, ifu_req_addr,
        input  ifu_req_ready, ifu_resp_valid, ifu_resp_inst,
        output lsu_req_valid, lsu_req_we, lsu_req_addr,
        input  lsu_req_ready, lsu_resp_valid, lsu_resp_rdata
    );

    modport slave (
        input  ifu_req_valid, ifu_req_addr,
        output ifu_req_ready, ifu_resp_valid, ifu_resp_inst,
        input  lsu_req_valid, lsu_req_we, lsu_req_addr,
        output lsu_req_ready, lsu_resp_valid, lsu_resp_rdata
    );
endinterface

// File: rtl/multicycle_core_ctrl.sv
// Multi-cycle RV32 sequencer: owns PC/IR/alu_q/load_q, drives fetch and data
// handshakes (mem), decoder hints in, rf_wen/halted/misaligned/state out.
// Optional YSYX_24070014_PERF_CNT_EN adds cycle_cnt and instret_cnt outputs.
module multicycle_core_ctrl #(
    parameter int              XLEN    = 32,
    parameter logic [XLEN-1:0] INIT_PC = 32'h8000_0000,
    parameter int              INST_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    multicycle_core_ctrl_if.master mem,
    output logic [INST_W-1:0] inst,
    output logic [XLEN-1:0]   pc,
    input  logic              dec_pc_sel,
    input  logic              dec_reg_write_en,
    input  logic              dec_mem_read_en,
    input  logic              dec_mem_write_en,
    input  logic              dec_ebreak,
    input  logic [XLEN-1:0]   alu_out,
    output logic [XLEN-1:0]   alu_q,
    output logic [XLEN-1:0]   load_q,
    output logic              rf_wen,
    output logic              halted,
    output logic              misaligned,
`ifdef YSYX_24070014_PERF_CNT_EN
    output logic [XLEN-1:0]   cycle_cnt,
    output logic [XLEN-1:0]   instret_cnt,
`endif
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        S_FETCH_REQ  = 3'd0,
        S_FETCH_WAIT = 3'd1,
        S_EXEC       = 3'd2,
        S_MEM_REQ    = 3'd3,
        S_MEM_WAIT   = 3'd4,
        S_WB         = 3'd5,
        S_HALT       = 3'd6
    } state_t;

    state_t          st;
    logic            ifu_v;
    logic            lsu_v;
    logic            lsu_we;
    logic [XLEN-1:0] next_pc;

    assign state              = st;
    assign mem.ifu_req_valid  = ifu_v;
    assign mem.ifu_req_addr   = pc;
    assign mem.lsu_req_valid  = lsu_v;
    assign mem.lsu_req_we     = lsu_we;
    assign mem.lsu_req_addr   = alu_q;

    assign next_pc = dec_pc_sel ? alu_q : pc + XLEN'(4);

    always_ff @(posedge clk) begin
        if (!reset) begin
            st         <= S_FETCH_REQ;
            pc         <= INIT_PC;
            inst       <= '0;
            alu_q      <= '0;
            load_q     <= '0;
            halted     <= 1'b0;
            misaligned <= 1'b0;
            rf_wen     <= 1'b0;
            ifu_v      <= 1'b0;
            lsu_v      <= 1'b0;
            lsu_we     <= 1'b0;
`ifdef YSYX_24070014_PERF_CNT_EN
            cycle_cnt   <= '0;
            instret_cnt <= '0;
`endif
        end else begin
            rf_wen <= 1'b0;
`ifdef YSYX_24070014_PERF_CNT_EN
            if (!halted)
                cycle_cnt <= cycle_cnt + XLEN'(1);
`endif
            unique case (st)
                S_FETCH_REQ: begin
                    // valid rises one cycle after reset release
                    ifu_v <= 1'b1;
                    if (ifu_v && mem.ifu_req_ready) begin
                        ifu_v <= 1'b0;
                        st    <= S_FETCH_WAIT;
                    end
                end
                S_FETCH_WAIT: begin
                    if (mem.ifu_resp_valid) begin
                        inst <= mem.ifu_resp_inst;
                        st   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    alu_q <= alu_out;
                    if (dec_ebreak) begin
                        halted <= 1'b1;
                        st     <= S_HALT;
                    end else if (dec_mem_read_en || dec_mem_write_en) begin
                        // read+write together resolves to a store
                        lsu_v  <= 1'b1;
                        lsu_we <= dec_mem_write_en;
                        st     <= S_MEM_REQ;
                    end else begin
                        rf_wen <= dec_reg_write_en;
                        st     <= S_WB;
                    end
                end
                S_MEM_REQ: begin
                    if (lsu_v && mem.lsu_req_ready) begin
                        lsu_v <= 1'b0;
                        st    <= S_MEM_WAIT;
                    end
                end
                S_MEM_WAIT: begin
                    if (mem.lsu_resp_valid) begin
                        if (!lsu_we)
                            load_q <= mem.lsu_resp_rdata;
                        rf_wen <= dec_reg_write_en;
                        st     <= S_WB;
                    end
                end
                S_WB: begin
                    if (next_pc[1:0] != 2'b00) begin
                        misaligned <= 1'b1;
                        halted     <= 1'b1;
                        st         <= S_HALT;
                    end else begin
                        pc    <= next_pc;
                        ifu_v <= 1'b1;
                        st    <= S_FETCH_REQ;
`ifdef YSYX_24070014_PERF_CNT_EN
                        instret_cnt <= instret_cnt + XLEN'(1);
`endif
                    end
                end
                default: begin
                    // HALT and the unused encoding 7 both park here
                    halted <= 1'b1;
                    ifu_v  <= 1'b0;
                    lsu_v  <= 1'b0;
                    st     <= S_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_core_ctrl.sv
// Randomized bench for multicycle_core_ctrl against a timeline reference model.
// Acts as memory slave and decoder; checks outputs every cycle.
module tb_multicycle_core_ctrl;

    localparam logic [31:0] INIT_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        dec_pc_sel = 1'b0;
    logic        dec_reg_write_en = 1'b0;
    logic        dec_mem_read_en = 1'b0;
    logic        dec_mem_write_en = 1'b0;
    logic        dec_ebreak = 1'b0;
    logic [31:0] alu_out = '0;
    logic [31:0] inst, pc, alu_q, load_q;
    logic        rf_wen, halted, misaligned;
    logic [2:0]  state;
`ifdef YSYX_24070014_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    multicycle_core_ctrl_if #(.XLEN(32), .INST_W(32)) mif ();

    multicycle_core_ctrl #(.XLEN(32), .INIT_PC(INIT_PC), .INST_W(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .mem              (mif),
        .inst             (inst),
        .pc               (pc),
        .dec_pc_sel       (dec_pc_sel),
        .dec_reg_write_en (dec_reg_write_en),
        .dec_mem_read_en  (dec_mem_read_en),
        .dec_mem_write_en (dec_mem_write_en),
        .dec_ebreak       (dec_ebreak),
        .alu_out          (alu_out),
        .alu_q            (alu_q),
        .load_q           (load_q),
        .rf_wen           (rf_wen),
        .halted           (halted),
        .misaligned       (misaligned),
`ifdef YSYX_24070014_PERF_CNT_EN
        .cycle_cnt        (cycle_cnt),
        .instret_cnt      (instret_cnt),
`endif
        .state            (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        bit          rd_we, pc_sel, mrd, mwr, ebrk;
        logic [31:0] alu, rdata;
        int          frw, fww, mrw, mww;
    } ins_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_pc, m_load_q;
    int unsigned m_cyc, m_ret;
    bit          m_halt, m_mis;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic ins_t mk(logic [31:0] w, bit we, bit ps, bit r, bit wr,
                                bit eb, logic [31:0] a, logic [31:0] rd,
                                int f0, int f1, int m0, int m1);
        ins_t d;
        d.word = w; d.rd_we = we; d.pc_sel = ps; d.mrd = r; d.mwr = wr;
        d.ebrk = eb; d.alu = a; d.rdata = rd;
        d.frw = f0; d.fww = f1; d.mrw = m0; d.mww = m1;
        return d;
    endfunction

    task automatic junk_inputs();
        mif.ifu_req_ready  = 1'($urandom);
        mif.ifu_resp_valid = 1'($urandom);
        mif.ifu_resp_inst  = $urandom;
        mif.lsu_req_ready  = 1'($urandom);
        mif.lsu_resp_valid = 1'($urandom);
        mif.lsu_resp_rdata = $urandom;
        dec_pc_sel = 1'($urandom); dec_reg_write_en = 1'($urandom);
        dec_mem_read_en = 1'($urandom); dec_mem_write_en = 1'($urandom);
        dec_ebreak = 1'($urandom); alu_out = $urandom;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        junk_inputs();
        mif.ifu_resp_valid = 1'b1;
        mif.lsu_resp_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", state, 0);
        chk("rst_pc", pc, INIT_PC);
        chk("rst_inst", inst, 0);
        chk("rst_alu_q", alu_q, 0);
        chk("rst_load_q", load_q, 0);
        chk("rst_ifu_v", mif.ifu_req_valid, 0);
        chk("rst_lsu_v", mif.lsu_req_valid, 0);
        chk("rst_rf_wen", rf_wen, 0);
        chk("rst_halted", halted, 0);
        chk("rst_mis", misaligned, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        m_pc = INIT_PC; m_load_q = '0; m_cyc = 1; m_ret = 0;
        m_halt = 0; m_mis = 0;
        chk("rel_state", state, 0);
        chk("rel_ifu_v", mif.ifu_req_valid, 1);
        chk("rel_addr", mif.ifu_req_addr, INIT_PC);
    endtask

    task automatic halt_wait();
        for (int i = 0; i < 20; i++) begin
            chk("halt_state", state, 6);
            chk("halt_ifu_v", mif.ifu_req_valid, 0);
            chk("halt_lsu_v", mif.lsu_req_valid, 0);
            chk("halt_rf_wen", rf_wen, 0);
            chk("halt_halted", halted, 1);
            chk("halt_mis", misaligned, 32'(m_mis));
            chk("halt_pc", pc, m_pc);
`ifdef YSYX_24070014_PERF_CNT_EN
            chk("halt_cycle_cnt", cycle_cnt, m_cyc);
            chk("halt_instret", instret_cnt, m_ret);
`endif
            junk_inputs();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run(input ins_t d, input int abort_at);
        int fr_end, fw_end, ex, mr_end, mw_end, wb, last, es;
        bit mem, in_mreq;
        logic [31:0] nxt;
        mem    = !d.ebrk && (d.mrd || d.mwr);
        fr_end = d.frw;
        fw_end = fr_end + 1 + d.fww;
        ex     = fw_end + 1;
        mr_end = ex + 1 + d.mrw;
        mw_end = mr_end + 1 + d.mww;
        wb     = mem ? mw_end + 1 : ex + 1;
        last   = d.ebrk ? ex : wb;
`ifdef YSYX_24070014_PERF_CNT_EN
        chk("cycle_cnt", cycle_cnt, m_cyc);
        chk("instret_cnt", instret_cnt, m_ret);
`endif
        for (int t = 0; t <= last; t++) begin
            in_mreq = mem && t > ex && t <= mr_end;
            if (t <= fr_end)                es = 0;
            else if (t <= fw_end)           es = 1;
            else if (t == ex)               es = 2;
            else if (mem && t <= mr_end)    es = 3;
            else if (mem && t <= mw_end)    es = 4;
            else                            es = 5;
            chk("state", state, es);
            chk("ifu_v", mif.ifu_req_valid, 32'(t <= fr_end));
            if (t <= fr_end)
                chk("ifu_addr", mif.ifu_req_addr, m_pc);
            chk("lsu_v", mif.lsu_req_valid, 32'(in_mreq));
            if (in_mreq) begin
                chk("lsu_addr", mif.lsu_req_addr, d.alu);
                chk("lsu_we", mif.lsu_req_we, 32'(d.mwr));
            end
            chk("rf_wen", rf_wen, (t == wb) ? 32'(d.rd_we) : 0);
            chk("pc", pc, m_pc);
            if (t >= ex) chk("inst", inst, d.word);
            if (t > ex)  chk("alu_q", alu_q, d.alu);

            mif.ifu_req_ready  = (t == fr_end) ? 1'b1 :
                                 (t > fr_end) ? 1'($urandom) : 1'b0;
            mif.ifu_resp_valid = (t == fw_end) ||
                                 (t == fr_end && 1'($urandom));
            mif.ifu_resp_inst  = (t == fw_end) ? d.word : $urandom;
            if (t >= ex) begin
                dec_pc_sel       = d.pc_sel;
                dec_reg_write_en = d.rd_we;
                dec_mem_read_en  = d.mrd;
                dec_mem_write_en = d.mwr;
                dec_ebreak       = d.ebrk;
            end else begin
                dec_pc_sel = 1'($urandom); dec_reg_write_en = 1'($urandom);
                dec_mem_read_en = 1'($urandom); dec_mem_write_en = 1'($urandom);
                dec_ebreak = 1'($urandom);
            end
            alu_out = (t == ex) ? d.alu : $urandom;
            mif.lsu_req_ready  = (mem && t == mr_end) ? 1'b1 :
                                 in_mreq ? 1'b0 : 1'($urandom);
            mif.lsu_resp_valid = mem && (t == mw_end ||
                                 (t == mr_end && 1'($urandom)));
            mif.lsu_resp_rdata = (t == mw_end) ? d.rdata : $urandom;
            if (t == abort_at) begin
                reset = 1'b0;
                mif.lsu_req_ready = 1'b0;
                @(posedge clk);
                #1;
                chk("abort_lsu_v", mif.lsu_req_valid, 0);
                chk("abort_state", state, 0);
                chk("abort_pc", pc, INIT_PC);
                chk("abort_ifu_v", mif.ifu_req_valid, 0);
                return;
            end
            @(posedge clk);
            #1;
        end
        m_cyc += unsigned'(last + 1);
        if (d.ebrk) begin
            m_halt = 1;
        end else begin
            if (mem && !d.mwr) m_load_q = d.rdata;
            nxt = d.pc_sel ? d.alu : m_pc + 32'd4;
            if (nxt[1:0] != 2'b00) begin
                m_halt = 1; m_mis = 1;
            end else begin
                m_pc = nxt; m_ret++;
            end
        end
        chk("end_pc", pc, m_pc);
        chk("end_load_q", load_q, m_load_q);
        chk("end_halted", halted, 32'(m_halt));
        chk("end_mis", misaligned, 32'(m_mis));
        chk("end_state", state, m_halt ? 6 : 0);
        chk("end_ifu_v", mif.ifu_req_valid, 32'(!m_halt));
        chk("end_rf_wen", rf_wen, 0);
        chk("end_inst", inst, d.word);
    endtask

    function automatic ins_t rnd_ins();
        int k;
        logic [31:0] a;
        ins_t d;
        k = $urandom_range(0, 19);
        a = $urandom;
        d = mk($urandom, 1'($urandom), 0, 0, 0, 0, a, $urandom,
               $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3));
        if (k < 6) begin
        end else if (k < 10) begin
            d.pc_sel = 1; d.alu = a & 32'hFFFF_FFFC;
        end else if (k < 14) begin
            d.mrd = 1; d.rd_we = 1;
        end else if (k < 18) begin
            d.mwr = 1; d.mrd = 1'($urandom); d.rd_we = 0;
        end else if (k == 18) begin
            d.pc_sel = 1; d.alu = (a & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
        end else begin
            d.word = 32'h0010_0073; d.ebrk = 1;
        end
        return d;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: no finish by %0t", $time);
        $fatal(1);
    end

    initial begin
        ins_t d;
        junk_inputs();
        do_reset();

        d = mk(32'h0050_0093, 1, 0, 0, 0, 0, 32'd5, 0, 0, 0, 0, 0);
        run(d, -1);
        chk("addi_pc", pc, 32'h8000_0004);

        d = mk(32'h0000_2083, 1, 0, 1, 0, 0, 32'h8000_1000,
               32'hDEAD_BEEF, 3, 0, 0, 2);
        run(d, -1);
        chk("load_q", load_q, 32'hDEAD_BEEF);

        d = mk(32'h0000_0063, 0, 1, 0, 0, 0, 32'h8000_0100, 0, 0, 0, 0, 0);
        run(d, -1);
        chk("br_pc", pc, 32'h8000_0100);
        d.alu = 32'h8000_0102;
        run(d, -1);
        chk("br_mis", misaligned, 1);
        chk("br_mis_pc", pc, 32'h8000_0100);
        halt_wait();
        do_reset();

        d = mk(32'h0010_0073, 0, 0, 0, 0, 1, $urandom, 0, 0, 0, 0, 0);
        run(d, -1);
        halt_wait();
        do_reset();

        d = mk($urandom, 0, 1, 0, 0, 0, 32'hFFFF_FFFC, 0, 0, 1, 0, 0);
        run(d, -1);
        d = mk($urandom, 1, 0, 0, 0, 0, $urandom, 0, 1, 0, 0, 0);
        run(d, -1);
        chk("wrap_pc", pc, 32'h0000_0000);

        d = mk($urandom, 1, 0, 1, 0, 0, 32'h8000_2000, $urandom, 0, 0, 3, 0);
        run(d, 4);
        do_reset();

        for (int i = 0; i < 300; i++) begin
            d = rnd_ins();
            run(d, -1);
            if (m_halt) begin
                halt_wait();
                do_reset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_core_ctrl.md
Name: multicycle_core_ctrl

Overview:
- Multi-cycle sequencer replacing the single-cycle fetch/execute/memory/writeback timing of the RV32 core.
- Owns PC, instruction register (IR), latched ALU result and latched load data.
- Talks to instruction and data memories through valid/ready request and response handshakes instead of combinational reads.
- The existing decoder, register file, immediate generator and ALU stay outside. They are driven from this block's IR and PC, and write-enabled by its rf_wen.

Parameters:
XLEN, 32, data/address width.
INIT_PC, 32'h8000_0000, PC value loaded on reset.
INST_W, 32, instruction width.

Ports:
clk  in  1  core clock, rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
ifu_req_valid  out  1  fetch request valid
ifu_req_ready  in  1  fetch request accepted
ifu_req_addr  out  XLEN  fetch address (= pc)
ifu_resp_valid  in  1  fetch data valid
ifu_resp_inst  in  INST_W  fetched instruction
inst  out  INST_W  IR, held stable from EXEC through WB
pc  out  XLEN  current PC
dec_pc_sel  in  1  decoder: 1 = next PC from ALU
dec_reg_write_en  in  1  decoder: instruction writes rd
dec_mem_read_en  in  1  decoder: load
dec_mem_write_en  in  1  decoder: store
dec_ebreak  in  1  decoder: ebreak
alu_out  in  XLEN  ALU result (branch target or memory address)
alu_q  out  XLEN  ALU result latched in EXEC
lsu_req_valid  out  1  data request valid
lsu_req_ready  in  1  data request accepted
lsu_req_we  out  1  1 = store
lsu_req_addr  out  XLEN  = alu_q
lsu_resp_valid  in  1  data response valid (loads and stores)
lsu_resp_rdata  in  XLEN  load data
load_q  out  XLEN  latched load data
rf_wen  out  1  register-file write enable
halted  out  1  core stopped (ebreak or misaligned PC)
misaligned  out  1  halt cause: next PC[1:0] != 0
state  out  3  FSM state encoding, for debug

Behaviour:
- Reset (reset==0 at a posedge):
  - state=FETCH_REQ, pc=INIT_PC.
  - inst, alu_q, load_q = 0.
  - halted, misaligned, rf_wen, ifu_req_valid, lsu_req_valid = 0.
  - Reset wins over every other event, including mid-handshake and in HALT. Outstanding responses after reset are ignored until a new request is issued.
- States and encodings: FETCH_REQ=0, FETCH_WAIT=1, EXEC=2, MEM_REQ=3, MEM_WAIT=4, WB=5, HALT=6. Encoding 7 -> HALT.
- FETCH_REQ:
  - ifu_req_valid=1, ifu_req_addr=pc.
  - Held with stable address until ifu_req_ready. On ready -> FETCH_WAIT.
- FETCH_WAIT:
  - ifu_req_valid=0. On ifu_resp_valid: inst<=ifu_resp_inst, -> EXEC.
  - A response asserted in the same cycle as the request handshake is not accepted. Earliest acceptance is the next cycle.
- EXEC:
  - alu_q<=alu_out.
  - If dec_ebreak -> HALT with halted=1; pc unchanged.
  - Else if dec_mem_read_en or dec_mem_write_en -> MEM_REQ.
  - Else -> WB.
  - If read and write are both set, the operation is treated as a store.
- MEM_REQ:
  - lsu_req_valid=1, lsu_req_we=dec_mem_write_en, lsu_req_addr=alu_q.
  - Held stable until lsu_req_ready -> MEM_WAIT.
- MEM_WAIT:
  - On lsu_resp_valid: if load, load_q<=lsu_resp_rdata; -> WB.
  - Same-cycle rule as FETCH_WAIT.
- WB (exactly one cycle):
  - rf_wen=dec_reg_write_en; rf_wen is 0 in every other state.
  - next = dec_pc_sel ? alu_q : pc+4, modulo 2^XLEN (wrap, no carry out).
  - If next[1:0]!=0: pc unchanged, misaligned=1, halted=1, -> HALT.
  - Else pc<=next, -> FETCH_REQ.
- HALT: all request valids and rf_wen are 0. Exit only by reset.
- Latency with always-ready memories and responses one cycle after accept:
  - ALU/branch instruction: 4 cycles (FETCH_REQ, FETCH_WAIT, EXEC, WB).
  - Load/store: 6 cycles.
- Back-pressure: any number of wait cycles in REQ or WAIT states is legal. No timeout.

Optional Feature:
- Macro: YSYX_24070014_PERF_CNT_EN.
- With the macro defined, two extra outputs:
  - cycle_cnt, XLEN wide: increments every cycle not in reset and not in HALT.
  - instret_cnt, XLEN wide: increments on every WB cycle that does not transition to HALT.
  - Both clear on reset, wrap at 2^XLEN, and freeze in HALT.
- Without the macro the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release -> pc=32'h8000_0000, state=0, ifu_req_valid=1 on the first cycle after release, all other outputs 0.
- addi x1,x0,5 (32'h00500093), zero-wait memories -> rf_wen=1 exactly in cycle 4, pc=32'h8000_0004 on cycle 5, instret_cnt=1 when PERF enabled.
- Load with ifu_req_ready low 3 cycles and lsu_resp_valid delayed 2 cycles -> ifu_req_addr and lsu_req_addr stable while waiting; load_q=32'hDEAD_BEEF; rf_wen for one cycle; total 11 cycles.
- Taken branch, alu_out=32'h8000_0100 -> pc=32'h8000_0100; same test with alu_out=32'h8000_0102 -> HALT, misaligned=1, pc unchanged.
- ebreak (32'h00100073) -> state=6, halted=1, no further ifu_req_valid for 20 cycles, cycle_cnt frozen.
- reset=0 asserted in MEM_REQ with lsu_req_ready=0 -> next cycle lsu_req_valid=0, state=0, pc=INIT_PC.
